// File: rtl/simple_decode_pipe.sv
// SIMPLE instruction decoder: valid/ready intake, one-cycle registered decode,
// DEPTH-entry write scoreboard for RAW stalls, flush and sticky halt.
module simple_decode_pipe #(
    parameter int DEPTH    = 3,
    parameter int DATA_W   = 16,
    parameter bit SEXT_IMM = 1'b1
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [15:0]       EXEC,
    input  logic              EXEC_VALID,
    output logic              EXEC_READY,
    input  logic              FLUSH,
    output logic              DEC_VALID,
    output logic [3:0]        S_ALU,
    output logic [2:0]        registerAddress1,
    output logic [2:0]        registerAddress2,
    output logic [2:0]        WB_ADDR,
    output logic              REG_WRITE,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic              BRANCH,
    output logic              IMM_SEL,
    output logic              HALT,
    output logic              ILLEGAL,
    output logic [2:0]        BR_COND,
    output logic [DATA_W-1:0] IMM
);

    typedef struct packed {
        logic [3:0]        s_alu;
        logic [2:0]        ra1;
        logic [2:0]        ra2;
        logic [2:0]        wb_addr;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic [2:0]        br_cond;
        logic              imm_sel;
        logic              halt;
        logic              illegal;
        logic [DATA_W-1:0] imm;
    } dec_t;

    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_ALU = 2'b11;

    logic [1:0] op1;
    logic [2:0] rs, rd;
    logic [7:0] d;
    logic [3:0] op3;

    assign op1 = EXEC[15:14];
    assign rs  = EXEC[13:11];
    assign rd  = EXEC[10:8];
    assign d   = EXEC[7:0];
    assign op3 = EXEC[7:4];

    dec_t              dec, dec_q;
    logic              rd_rs, rd_rd, ill;
    logic [DATA_W-1:0] imm_ext;
    logic              dec_valid_q, halted;
    logic              hazard, accept;

    logic [DEPTH-1:0]       sb_vld;
    logic [DEPTH-1:0][2:0]  sb_addr;
    logic [DEPTH-1:0]       sb_hit;

    always_comb begin
        imm_ext      = '0;
        imm_ext[7:0] = d;
        if (SEXT_IMM) begin
            for (int i = 8; i < DATA_W; i++) imm_ext[i] = d[7];
        end
    end

    // rd_rs / rd_rd flag which source fields feed the hazard compare.
    always_comb begin
        dec     = '0;
        rd_rs   = 1'b0;
        rd_rd   = 1'b0;
        ill     = 1'b0;
        dec.ra1 = rs;
        dec.ra2 = rd;
        dec.imm = imm_ext;
        case (op1)
            OP_ALU: begin
                dec.s_alu = op3;
                case (op3)
                    4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
                        rd_rs         = 1'b1;
                        rd_rd         = 1'b1;
                        dec.reg_write = 1'b1;
                        dec.wb_addr   = rd;
                    end
                    4'd5: begin
                        rd_rs = 1'b1;
                        rd_rd = 1'b1;
                    end
                    4'd6: begin
                        rd_rs         = 1'b1;
                        dec.reg_write = 1'b1;
                        dec.wb_addr   = rd;
                    end
                    4'd8, 4'd9, 4'd10, 4'd11: begin
                        rd_rd         = 1'b1;
                        dec.reg_write = 1'b1;
                        dec.wb_addr   = rd;
                        dec.imm_sel   = 1'b1;
                        dec.imm       = DATA_W'(d[3:0]);
                    end
                    4'd12: begin
                        dec.reg_write = 1'b1;
                        dec.wb_addr   = rd;
                    end
                    4'd13: rd_rs = 1'b1;
                    4'd15: begin
                        dec.s_alu = 4'd0;
                        dec.halt  = 1'b1;
                    end
                    default: ill = 1'b1;
                endcase
            end
            OP_LD: begin
                rd_rd         = 1'b1;
                dec.reg_write = 1'b1;
                dec.wb_addr   = rs;
                dec.mem_read  = 1'b1;
                dec.imm_sel   = 1'b1;
            end
            OP_ST: begin
                rd_rs         = 1'b1;
                rd_rd         = 1'b1;
                dec.mem_write = 1'b1;
                dec.imm_sel   = 1'b1;
            end
            default: begin
                case (rs)
                    3'b000: begin
                        dec.reg_write = 1'b1;
                        dec.wb_addr   = rd;
                        dec.imm_sel   = 1'b1;
                    end
                    3'b100: begin
                        dec.branch  = 1'b1;
                        dec.br_cond = 3'b111;
                    end
                    3'b111: begin
                        if (rd[2]) begin
                            ill = 1'b1;
                        end else begin
                            dec.branch  = 1'b1;
                            dec.br_cond = rd;
                        end
                    end
                    default: ill = 1'b1;
                endcase
            end
        endcase
        // Illegal words carry only the ILLEGAL flag and never read or write.
        if (ill) begin
            dec         = '0;
            dec.illegal = 1'b1;
            rd_rs       = 1'b0;
            rd_rd       = 1'b0;
        end
    end

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_sb_cmp
            assign sb_hit[k] = sb_vld[k] &&
                               ((rd_rs && (sb_addr[k] == rs)) ||
                                (rd_rd && (sb_addr[k] == rd)));
        end
    endgenerate

    assign hazard     = EXEC_VALID && (|sb_hit);
    assign EXEC_READY = !RESET && !FLUSH && !halted && !hazard;
    assign accept     = EXEC_VALID && EXEC_READY;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            dec_valid_q <= 1'b0;
            dec_q       <= '0;
            halted      <= 1'b0;
        end else begin
            dec_valid_q <= accept;
            if (accept) begin
                dec_q <= dec;
                if (dec.halt) halted <= 1'b1;
            end
        end
    end

    // Entry 0 is the instruction accepted this cycle; entry DEPTH-1 retires.
    always_ff @(posedge CLOCK) begin
        if (RESET || FLUSH) begin
            sb_vld  <= '0;
            sb_addr <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                sb_vld[i]  <= sb_vld[i-1];
                sb_addr[i] <= sb_addr[i-1];
            end
            sb_vld[0]  <= accept && dec.reg_write;
            sb_addr[0] <= dec.wb_addr;
        end
    end

    assign DEC_VALID        = dec_valid_q;
    assign S_ALU            = dec_q.s_alu;
    assign registerAddress1 = dec_q.ra1;
    assign registerAddress2 = dec_q.ra2;
    assign WB_ADDR          = dec_q.wb_addr;
    assign REG_WRITE        = dec_q.reg_write;
    assign MEM_READ         = dec_q.mem_read;
    assign MEM_WRITE        = dec_q.mem_write;
    assign BRANCH           = dec_q.branch;
    assign BR_COND          = dec_q.br_cond;
    assign IMM_SEL          = dec_q.imm_sel;
    // HALT is a pulse, unlike the other fields which hold between accepts.
    assign HALT             = dec_q.halt && dec_valid_q;
    assign ILLEGAL          = dec_q.illegal;
    assign IMM              = dec_q.imm;

endmodule

// File: tb/tb_simple_decode_pipe.sv
// Scoreboard bench for simple_decode_pipe: expected decodes queued on accept,
// compared when DEC_VALID appears; stall/flush/halt/reset checked in tasks.
module tb_simple_decode_pipe;

    logic        CLOCK = 1'b0;
    logic        RESET, EXEC_VALID, FLUSH;
    logic [15:0] EXEC;
    logic        EXEC_READY, DEC_VALID;
    logic [3:0]  S_ALU;
    logic [2:0]  registerAddress1, registerAddress2, WB_ADDR, BR_COND;
    logic        REG_WRITE, MEM_READ, MEM_WRITE, BRANCH, IMM_SEL, HALT, ILLEGAL;
    logic [15:0] IMM;

    always #5 CLOCK = ~CLOCK;

    simple_decode_pipe #(.DEPTH(3), .DATA_W(16), .SEXT_IMM(1'b1)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .EXEC(EXEC), .EXEC_VALID(EXEC_VALID),
        .EXEC_READY(EXEC_READY), .FLUSH(FLUSH), .DEC_VALID(DEC_VALID),
        .S_ALU(S_ALU), .registerAddress1(registerAddress1),
        .registerAddress2(registerAddress2), .WB_ADDR(WB_ADDR),
        .REG_WRITE(REG_WRITE), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .BRANCH(BRANCH), .IMM_SEL(IMM_SEL), .HALT(HALT), .ILLEGAL(ILLEGAL),
        .BR_COND(BR_COND), .IMM(IMM)
    );

    typedef struct packed {
        logic [3:0]  s_alu;
        logic [2:0]  ra1, ra2, wb;
        logic        rw, mr, mw, br;
        logic [2:0]  cond;
        logic        isel, hlt, ill;
        logic [15:0] imm;
    } exp_t;

    exp_t        exp_q[$];
    int          passed = 0;
    int          total  = 0;
    exp_t        act;
    logic [39:0] all_out;

    assign act = {S_ALU, registerAddress1, registerAddress2, WB_ADDR, REG_WRITE,
                  MEM_READ, MEM_WRITE, BRANCH, BR_COND, IMM_SEL, HALT, ILLEGAL, IMM};
    assign all_out = {DEC_VALID, act};

    function automatic exp_t mk(input logic [3:0] s, input logic [2:0] a1, a2, wb,
                                input logic rw, mr, mw, br, input logic [2:0] cond,
                                input logic isel, hlt, ill, input logic [15:0] imm);
        mk = {s, a1, a2, wb, rw, mr, mw, br, cond, isel, hlt, ill, imm};
    endfunction

    always @(negedge CLOCK) begin
        if (RESET === 1'b0 && DEC_VALID === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL dec_unexpected: got %h, required no DEC_VALID", act);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (act !== e) $display("FAIL dec_out: got %h, required %h", act, e);
                else passed++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLOCK);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] w, input exp_t e, output int stalls);
        EXEC       = w;
        EXEC_VALID = 1'b1;
        #1;
        stalls = 0;
        while (EXEC_READY !== 1'b1 && stalls < 40) begin
            @(negedge CLOCK);
            #1;
            stalls++;
        end
        if (EXEC_READY !== 1'b1) begin
            total++;
            $display("FAIL send_timeout: word %h not accepted, required accept within 40 cycles", w);
            EXEC_VALID = 1'b0;
        end else begin
            exp_q.push_back(e);
            @(negedge CLOCK);
            #1;
            EXEC_VALID = 1'b0;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; FLUSH = 1'b0; EXEC_VALID = 1'b0; EXEC = 16'h0000;
        idle(2);
        total++;
        if (all_out !== 40'd0) $display("FAIL reset_outputs: got %h, required 0", all_out);
        else passed++;
        total++;
        if (EXEC_READY !== 1'b0) $display("FAIL ready_in_reset: got %b, required 0", EXEC_READY);
        else passed++;
        RESET = 1'b0;
        #1;
        total++;
        if (EXEC_READY !== 1'b1) $display("FAIL ready_after_reset: got %b, required 1", EXEC_READY);
        else passed++;
    endtask

    task automatic test_stream();
        int s1, s2, s3;
        send(16'hCA00, mk(4'd0, 3'd1, 3'd2, 3'd2, 1,0,0,0, 3'd0, 0,0,0, 16'h0000), s1);
        send(16'h83FF, mk(4'd0, 3'd0, 3'd3, 3'd3, 1,0,0,0, 3'd0, 1,0,0, 16'hFFFF), s2);
        send(16'h2502, mk(4'd0, 3'd4, 3'd5, 3'd4, 1,1,0,0, 3'd0, 1,0,0, 16'h0002), s3);
        total++;
        if (s1 + s2 + s3 !== 0) $display("FAIL stream_stalls: got %0d, required 0", s1 + s2 + s3);
        else passed++;
        idle(1);
        total++;
        if (DEC_VALID !== 1'b0) $display("FAIL dv_idle: got %b, required 0", DEC_VALID);
        else passed++;
        idle(4);
    endtask

    task automatic test_raw_stall();
        int s1, s2;
        send(16'hCA60, mk(4'd6, 3'd1, 3'd2, 3'd2, 1,0,0,0, 3'd0, 0,0,0, 16'h0060), s1);
        send(16'hD300, mk(4'd0, 3'd2, 3'd3, 3'd3, 1,0,0,0, 3'd0, 0,0,0, 16'h0000), s2);
        total++;
        if (s1 !== 0) $display("FAIL mov_stall: got %0d, required 0", s1);
        else passed++;
        total++;
        if (s2 !== 3) $display("FAIL raw_stall_cycles: got %0d, required 3", s2);
        else passed++;
        idle(4);
    endtask

    task automatic test_flush();
        EXEC = 16'h8205; EXEC_VALID = 1'b1;
        #1;
        total++;
        if (EXEC_READY !== 1'b1) $display("FAIL flush_writer_ready: got %b, required 1", EXEC_READY);
        else begin
            passed++;
            exp_q.push_back(mk(4'd0, 3'd0, 3'd2, 3'd2, 1,0,0,0, 3'd0, 1,0,0, 16'h0005));
        end
        idle(1);
        EXEC = 16'hD0D0; FLUSH = 1'b1;
        #1;
        total++;
        if (EXEC_READY !== 1'b0) $display("FAIL flush_blocks: got %b, required 0", EXEC_READY);
        else passed++;
        idle(1);
        FLUSH = 1'b0;
        #1;
        total++;
        if (EXEC_READY !== 1'b1) $display("FAIL post_flush_ready: got %b, required 1", EXEC_READY);
        else begin
            passed++;
            exp_q.push_back(mk(4'd13, 3'd2, 3'd0, 3'd0, 0,0,0,0, 3'd0, 0,0,0, 16'hFFD0));
        end
        idle(1);
        EXEC_VALID = 1'b0;
        idle(4);
    endtask

    task automatic test_halt();
        int s, rdy;
        send(16'hC0F0, mk(4'd0, 3'd0, 3'd0, 3'd0, 0,0,0,0, 3'd0, 0,1,0, 16'hFFF0), s);
        idle(1);
        total++;
        if ({HALT, DEC_VALID} !== 2'b00) $display("FAIL halt_pulse: got %b, required 00", {HALT, DEC_VALID});
        else passed++;
        EXEC = 16'h8101; EXEC_VALID = 1'b1;
        rdy = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) FLUSH = 1'b1;
            if (i == 6) FLUSH = 1'b0;
            @(negedge CLOCK);
            #1;
            if (EXEC_READY !== 1'b0) rdy++;
        end
        total++;
        if (rdy !== 0) $display("FAIL halted_ready: got %0d ready cycles, required 0", rdy);
        else passed++;
        RESET = 1'b1;
        idle(1);
        RESET = 1'b0;
        #1;
        total++;
        if (EXEC_READY !== 1'b1) $display("FAIL ready_after_halt_reset: got %b, required 1", EXEC_READY);
        else passed++;
        EXEC_VALID = 1'b0;
        idle(2);
    endtask

    task automatic test_illegal();
        int s_sh, s_a, s_b, s_c, s_st, s_br;
        exp_t ie;
        ie = mk(4'd0, 3'd0, 3'd0, 3'd0, 0,0,0,0, 3'd0, 0,0,1, 16'h0000);
        send(16'hC3B5, mk(4'd11, 3'd0, 3'd3, 3'd3, 1,0,0,0, 3'd0, 1,0,0, 16'h0005), s_sh);
        send(16'h8800, ie, s_a);
        send(16'hC070, ie, s_b);
        send(16'hBC00, ie, s_c);
        send(16'h4400, mk(4'd0, 3'd0, 3'd4, 3'd0, 0,0,1,0, 3'd0, 1,0,0, 16'h0000), s_st);
        send(16'hB910, mk(4'd0, 3'd7, 3'd1, 3'd0, 0,0,0,1, 3'd1, 0,0,0, 16'h0010), s_br);
        total++;
        if (s_st !== 0) $display("FAIL illegal_no_stall: got %0d, required 0", s_st);
        else passed++;
        total++;
        if (s_a + s_b + s_c + s_br !== 0)
            $display("FAIL illegal_stream_stalls: got %0d, required 0", s_a + s_b + s_c + s_br);
        else passed++;
        idle(4);
    endtask

    task automatic test_reset_stall();
        int s;
        send(16'hCA60, mk(4'd6, 3'd1, 3'd2, 3'd2, 1,0,0,0, 3'd0, 0,0,0, 16'h0060), s);
        EXEC = 16'hD300; EXEC_VALID = 1'b1;
        #1;
        total++;
        if (EXEC_READY !== 1'b0) $display("FAIL stall_pending: got %b, required 0", EXEC_READY);
        else passed++;
        RESET = 1'b1;
        idle(1);
        total++;
        if (all_out !== 40'd0) $display("FAIL reset_mid_stall: got %h, required 0", all_out);
        else passed++;
        RESET = 1'b0;
        #1;
        total++;
        if (EXEC_READY !== 1'b1) $display("FAIL stall_after_reset: got %b, required 1", EXEC_READY);
        else begin
            passed++;
            exp_q.push_back(mk(4'd0, 3'd2, 3'd3, 3'd3, 1,0,0,0, 3'd0, 0,0,0, 16'h0000));
        end
        idle(1);
        EXEC_VALID = 1'b0;
        idle(3);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_raw_stall();
        test_flush();
        test_halt();
        test_illegal();
        test_reset_stall();
        total++;
        if (exp_q.size() !== 0) $display("FAIL sb_drain: got %0d pending, required 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/simple_decode_pipe.md
Name: simple_decode_pipe

Overview:
Parametrised successor to the current SIMPLE control unit. It accepts 16-bit SIMPLE instructions over a valid/ready handshake and decodes every opcode class (arith op3, load/store, LI/B/conditional branch, HLT) into registered control signals. It tracks in-flight register writes in a DEPTH-entry scoreboard and stalls on RAW hazards. It supports pipeline flush and halt latching, and sits between instruction fetch and the register file/ALU.

Parameters:
DEPTH, 3, scoreboard depth = cycles from decode to register writeback; legal range 1..8.
DATA_W, 16, width of the IMM output; must be >= 8.
SEXT_IMM, 1, 1 = sign-extend d[7:0] into IMM; 0 = zero-extend.

Ports:
CLOCK  in  1  system clock; all state updates on its rising edge.
RESET  in  1  synchronous, active-high reset.
EXEC  in  16  instruction word: OP1=[15:14], Rs=[13:11], Rd=[10:8], d=[7:0].
EXEC_VALID  in  1  EXEC holds a valid instruction.
EXEC_READY  out  1  combinational; the instruction is accepted when EXEC_VALID && EXEC_READY.
FLUSH  in  1  discards everything in flight (taken branch).
DEC_VALID  out  1  decoded outputs are valid this cycle.
S_ALU  out  4  ALU select, equal to d[7:4] for arith; 4'b0000 (ADD) for LD/ST address computation; otherwise 0.
registerAddress1  out  3  read port 1 address (Rs field).
registerAddress2  out  3  read port 2 address (Rd field).
WB_ADDR  out  3  destination register.
REG_WRITE, MEM_READ, MEM_WRITE, BRANCH, IMM_SEL, HALT, ILLEGAL  out  1 each  decoded controls.
BR_COND  out  3  condition code: 000 BE, 001 BLT, 010 BLE, 011 BNE, 111 unconditional.
IMM  out  DATA_W  extended d[7:0]; for shift ops, zero-extended d[3:0].

Behaviour:
Reset:
- All outputs 0, scoreboard entries invalid, halted flag cleared.
- Reset overrides FLUSH and any handshake in the same cycle.

Latency and output registering:
- An instruction accepted at edge N drives DEC_VALID=1 with its decoded fields during cycle N+1. Latency is 1.
- Decoded outputs hold their values while DEC_VALID=0.
- The decode rules below apply only when the instruction is not illegal.

OP1=11 (arith/op3, op3 = d[7:4]):
- ADD 0, SUB 1, AND 2, OR 3, XOR 4: read Rs and Rd, write Rd.
- CMP 5: read Rs and Rd, no write.
- MOV 6: read Rs, write Rd.
- SLL 8, SLR 9, SRL 10, SRA 11: read Rd, write Rd, IMM_SEL=1.
- IN 12: write Rd, no reads.
- OUT 13: read Rs.
- HLT 15: HALT=1.
- op3 7 and 14: illegal.

OP1=00 (LD Ra, d(Rb)):
- Ra = Rs field, Rb = Rd field.
- Read Rb, write Ra (WB_ADDR = Rs field), MEM_READ=1, IMM_SEL=1.

OP1=01 (ST Ra, d(Rb)):
- Read Ra and Rb, MEM_WRITE=1, IMM_SEL=1.

OP1=10 (op2, selected by the Rs field):
- 000 LI: write Rd, IMM_SEL=1, no reads.
- 100 B: BRANCH=1, BR_COND=111.
- 111 conditional branch: BRANCH=1, BR_COND = Rd field; Rd codes 100–111 are illegal.
- All other Rs codes: illegal.

Illegal instructions:
- ILLEGAL=1, DEC_VALID=1, all other controls 0, no scoreboard entry.

Scoreboard:
- DEPTH entries of {valid, addr}. Every cycle, entry k moves to k+1 and entry DEPTH-1 retires.
- Entry 0 takes {REG_WRITE, WB_ADDR} of the instruction accepted this cycle; otherwise it takes a bubble (invalid).

Hazard and EXEC_READY:
- Hazard: EXEC_VALID is high and any register the instruction reads matches the addr of any valid entry.
- EXEC_READY = !RESET && !FLUSH && !halted && !hazard.
- A stalled instruction must be held stable by the source. The stall resolves within DEPTH cycles.

FLUSH:
- On the next edge: all scoreboard entries invalid and DEC_VALID=0.
- Any instruction offered during the FLUSH cycle is not accepted.

Halt:
- Accepting HLT sets the halted flag. EXEC_READY then stays 0 until RESET.
- FLUSH does not clear the halted flag.
- HALT output pulses with that instruction's DEC_VALID.

No-accept cycles:
- DEC_VALID=0 in every cycle without an accept.

Test Plan:
1. Reset, then stream: ADD R1,R2 = 0xCA00, then LI R3,0xFF = 0x83FF, then LD R4,2(R5) = 0x2502 -> three consecutive DEC_VALID pulses.
   - ADD: S_ALU=0, REG_WRITE=1, WB_ADDR=2.
   - LI: IMM=0xFFFF, WB_ADDR=3.
   - LD: MEM_READ=1, WB_ADDR=4, registerAddress2=5.
2. With DEPTH=3: MOV R1→R2 = 0xCA60, then immediately ADD R2,R3 = 0xD300 -> EXEC_READY=0 for exactly 3 cycles; ADD is accepted on the 4th cycle.
3. Issue a write to R2, then assert FLUSH one cycle later with a dependent instruction offered -> the dependent instruction is not accepted during FLUSH. After the flush edge, the hazard is cleared and it is accepted next cycle with no further stall.
4. HLT = 0xC0F0 accepted -> HALT=1 for one cycle. EXEC_READY stays 0 for 20 cycles with EXEC_VALID=1. After RESET, EXEC_READY=1.
5. Illegal words 0x8800 (op2=001), 0xC070 (op3=7), 0xBC00 (cond Rd=100) -> ILLEGAL=1, REG_WRITE=0, no stall on a following read of R0/R4.
6. Assert RESET while a stall is pending -> all outputs 0 and scoreboard cleared on the next cycle. The stalled instruction is accepted on the first cycle after reset.
